// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between a client, the load/store unit and its RAM.
interface lsu_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 32
);

  logic              start;
  logic              isStore;
  logic [1:0]        size;
  logic              signedLd;
  logic [AWIDTH-1:0] addrIn;
  logic [WIDTH-1:0]  storeData;
  logic [WIDTH-1:0]  memRData;
  logic              memAck;

  logic              memReq;
  logic              memWr;
  logic [AWIDTH-1:0] memAddr;
  logic [WIDTH/8-1:0] memBe;
  logic [WIDTH-1:0]  memWData;
  logic              busy;
  logic              done;
  logic              fault;
  logic [WIDTH-1:0]  loadData;

  // The LSU itself sits on the slave side; the client/RAM model drives the master side.
  modport slave (
    input  start, isStore, size, signedLd, addrIn, storeData, memRData, memAck,
    output memReq, memWr, memAddr, memBe, memWData, busy, done, fault, loadData
  );

  modport master (
    output start, isStore, size, signedLd, addrIn, storeData, memRData, memAck,
    input  memReq, memWr, memAddr, memBe, memWData, busy, done, fault, loadData
  );

endinterface

// File: rtl/lsu_align.sv
// Selects the addressed byte/half lane of a RAM word and sign- or zero-extends it.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]               rdata_i,
  input  logic [$clog2(WIDTH/8)-1:0]     offset_i,
  input  logic [1:0]                     size_i,
  input  logic                           signedLd_i,
  output logic [WIDTH-1:0]               data_o
);

  logic [WIDTH-1:0] shifted;

  // Bring the addressed lane down to bit 0, then fill the upper bits bit-by-bit
  // so the same code works for any WIDTH of 16 or more.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = '0;
    case (size_i)
      SZ_BYTE: begin
        data_o[7:0] = shifted[7:0];
        for (int b = 8; b < WIDTH; b++) data_o[b] = signedLd_i & shifted[7];
      end
      SZ_HALF: begin
        data_o[15:0] = shifted[15:0];
        for (int b = 16; b < WIDTH; b++) data_o[b] = signedLd_i & shifted[15];
      end
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns requests onto a word-wide RAM port,
// replicates store data across lanes, extends load data and times out silent RAMs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AWIDTH   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);

  localparam int NB   = WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(MAX_WAIT + 1);

  lsu_state_e        state_q;
  logic [CW-1:0]     waitCnt_q;
  logic [OFFW-1:0]   offset_q;
  logic [1:0]        size_q;
  logic              isStore_q;
  logic              signedLd_q;
  logic              memReq_q;
  logic              memWr_q;
  logic [AWIDTH-1:0] memAddr_q;
  logic [NB-1:0]     memBe_q;
  logic [WIDTH-1:0]  memWData_q;
  logic              busy_q;
  logic              done_q;
  logic              fault_q;
  logic [WIDTH-1:0]  loadData_q;

  logic [OFFW-1:0]   offsetIn;
  logic              badAccess;
  logic [NB-1:0]     memBe_d;
  logic [WIDTH-1:0]  memWData_d;
  logic [WIDTH-1:0]  loadData_d;

  // Decode the incoming request: lane enables, replicated write data and legality.
  always_comb begin
    offsetIn   = bus.addrIn[OFFW-1:0];
    badAccess  = 1'b0;
    memBe_d    = '0;
    memWData_d = bus.storeData;
    case (bus.size)
      SZ_BYTE: begin
        memBe_d    = NB'(1) << offsetIn;
        memWData_d = {NB{bus.storeData[7:0]}};
      end
      SZ_HALF: begin
        badAccess  = offsetIn[0];
        memBe_d    = NB'(3) << offsetIn;
        memWData_d = {(NB/2){bus.storeData[15:0]}};
      end
      SZ_WORD: begin
        badAccess  = |offsetIn;
        memBe_d    = '1;
      end
      default: badAccess = 1'b1;
    endcase
  end

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .rdata_i    (bus.memRData),
    .offset_i   (offset_q),
    .size_i     (size_q),
    .signedLd_i (signedLd_q),
    .data_o     (loadData_d)
  );

  // All bus outputs are registered here; done/fault default low so they pulse once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      waitCnt_q  <= '0;
      offset_q   <= '0;
      size_q     <= SZ_BYTE;
      isStore_q  <= 1'b0;
      signedLd_q <= 1'b0;
      memReq_q   <= 1'b0;
      memWr_q    <= 1'b0;
      memAddr_q  <= '0;
      memBe_q    <= '0;
      memWData_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      loadData_q <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            offset_q   <= offsetIn;
            size_q     <= bus.size;
            isStore_q  <= bus.isStore;
            signedLd_q <= bus.signedLd;
            busy_q     <= 1'b1;
            if (badAccess) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q    <= ST_REQ;
              waitCnt_q  <= '0;
              memReq_q   <= 1'b1;
              memWr_q    <= bus.isStore;
              memAddr_q  <= {bus.addrIn[AWIDTH-1:OFFW], {OFFW{1'b0}}};
              memBe_q    <= memBe_d;
              memWData_q <= memWData_d;
            end
          end
        end
        ST_REQ: begin
          if (!bus.memAck) waitCnt_q <= waitCnt_q + CW'(1);
          // An ack arriving on the final allowed cycle still counts as success.
          if (bus.memAck || waitCnt_q == CW'(MAX_WAIT - 1)) begin
            state_q  <= ST_RESP;
            memReq_q <= 1'b0;
            memWr_q  <= 1'b0;
            memBe_q  <= '0;
            done_q   <= 1'b1;
            fault_q  <= ~bus.memAck;
            if (bus.memAck && !isStore_q) loadData_q <= loadData_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.memReq   = memReq_q;
  assign bus.memWr    = memWr_q;
  assign bus.memAddr  = memAddr_q;
  assign bus.memBe    = memBe_q;
  assign bus.memWData = memWData_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.fault    = fault_q;
  assign bus.loadData = loadData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level timeline model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int WIDTH    = 32;
  localparam int AWIDTH   = 32;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;

  lsu_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

  load_store_unit #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic st, input logic store, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] sd, input logic ack,
                               input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus.start     = st;
    bus.isStore   = store;
    bus.size      = sz;
    bus.signedLd  = sgn;
    bus.addrIn    = addr;
    bus.storeData = sd;
    bus.memAck    = ack;
    bus.memRData  = rd;
  endtask

  task automatic idleCycle(input logic ack, input logic [31:0] rd);
    applyStimulus(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0, ack, rd);
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] rd, input int off, input int sz, input logic sgn);
    int v;
    case (sz)
      0: begin
        v = int'((rd >> (8 * off)) & 32'hFF);
        if (sgn && v >= 128) v = v - 256;
      end
      1: begin
        v = int'((rd >> (8 * off)) & 32'hFFFF);
        if (sgn && v >= 32768) v = v - 65536;
      end
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  // Timeline model: an accepted access occupies cycles txStart+1 .. txEnd, where txEnd is the
  // done cycle; it becomes known at acceptance (fault), at the ack, or after MAX_WAIT silent cycles.
  initial begin : compareProc
    int          cyc;
    logic        txActive;
    int          txStart;
    int          txEnd;
    logic        mBad, mFault, mStore, mSgn;
    int          mSize, mOff;
    logic [31:0] mAddr, mWData, mLoad;
    logic [3:0]  mBe;
    logic        active, expReq, expDone;
    cyc = 0; txActive = 1'b0; txStart = 0; txEnd = -1;
    mBad = 1'b0; mFault = 1'b0; mStore = 1'b0; mSgn = 1'b0; mSize = 0; mOff = 0;
    mAddr = '0; mWData = '0; mLoad = '0; mBe = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        checkOutput("rst.memReq", bus.memReq, 0);
        checkOutput("rst.memWr", bus.memWr, 0);
        checkOutput("rst.memBe", bus.memBe, 0);
        checkOutput("rst.memAddr", bus.memAddr, 0);
        checkOutput("rst.memWData", bus.memWData, 0);
        checkOutput("rst.busy", bus.busy, 0);
        checkOutput("rst.done", bus.done, 0);
        checkOutput("rst.fault", bus.fault, 0);
        checkOutput("rst.loadData", bus.loadData, 0);
        txActive = 1'b0;
        mLoad    = '0;
      end else begin
        active  = txActive && (txEnd < 0 || cyc <= txEnd);
        expReq  = active && (txEnd < 0);
        expDone = active && (cyc == txEnd);
        checkOutput("cmp.busy", bus.busy, active);
        checkOutput("cmp.memReq", bus.memReq, expReq);
        checkOutput("cmp.memWr", bus.memWr, expReq && mStore);
        checkOutput("cmp.memBe", bus.memBe, expReq ? mBe : 4'h0);
        checkOutput("cmp.done", bus.done, expDone);
        checkOutput("cmp.fault", bus.fault, expDone && mFault);
        checkOutput("cmp.loadData", bus.loadData, mLoad);
        if (expReq) begin
          checkOutput("cmp.memAddr", bus.memAddr, mAddr);
          checkOutput("cmp.memWData", bus.memWData, mWData);
        end
        if (!active) begin
          txActive = 1'b0;
          if (bus.start) begin
            mStore  = bus.isStore;
            mSgn    = bus.signedLd;
            mSize   = int'(bus.size);
            mOff    = int'(bus.addrIn % 4);
            mAddr   = bus.addrIn & ~32'h3;
            mBad    = (mSize == 3) || (mSize == 1 && (mOff % 2) != 0) || (mSize == 2 && mOff != 0);
            mBe     = (mSize == 0) ? 4'(1 << mOff) : (mSize == 1) ? 4'(3 << mOff) : 4'hF;
            mWData  = (mSize == 0) ? {24'd0, bus.storeData[7:0]} * 32'h01010101 :
                      (mSize == 1) ? {16'd0, bus.storeData[15:0]} * 32'h00010001 : bus.storeData;
            txStart  = cyc;
            txActive = 1'b1;
            mFault   = mBad;
            txEnd    = mBad ? cyc + 1 : -1;
          end
        end else if (expReq) begin
          if (bus.memAck) begin
            txEnd  = cyc + 1;
            mFault = 1'b0;
            if (!mStore) mLoad = expLoad(bus.memRData, mOff, mSize, mSgn);
          end else if (cyc - txStart == MAX_WAIT) begin
            txEnd  = cyc + 1;
            mFault = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int reqCycles;
    int doneCnt;
    logic gotDone;
    bus.start = 1'b0; bus.isStore = 1'b0; bus.size = SZ_BYTE; bus.signedLd = 1'b0;
    bus.addrIn = '0; bus.storeData = '0; bus.memAck = 1'b0; bus.memRData = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    idleCycle(1'b0, 32'h0);
    checkOutput("reset.busy", bus.busy, 0);
    checkOutput("reset.loadData", bus.loadData, 0);

    // Word store with two wait cycles before the ack.
    applyStimulus(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput("wst.memReq", bus.memReq, 1);
    checkOutput("wst.memWr", bus.memWr, 1);
    checkOutput("wst.memAddr", bus.memAddr, 32'h100);
    checkOutput("wst.memBe", bus.memBe, 4'b1111);
    checkOutput("wst.memWData", bus.memWData, 32'hDEADBEEF);
    idleCycle(1'b0, 32'h0);
    idleCycle(1'b1, 32'h0);
    checkOutput("wst.memReqHeld", bus.memReq, 1);
    idleCycle(1'b0, 32'h0);
    checkOutput("wst.done", bus.done, 1);
    checkOutput("wst.fault", bus.fault, 0);
    checkOutput("wst.memWrOff", bus.memWr, 0);
    idleCycle(1'b0, 32'h0);
    checkOutput("wst.doneOnce", bus.done, 0);
    checkOutput("wst.idle", bus.busy, 0);

    // Signed then unsigned byte load from lane 3.
    applyStimulus(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h80123456);
    checkOutput("sbl.memBe", bus.memBe, 4'b1000);
    checkOutput("sbl.memAddr", bus.memAddr, 32'h200);
    checkOutput("sbl.memWr", bus.memWr, 0);
    idleCycle(1'b0, 32'h0);
    checkOutput("sbl.done", bus.done, 1);
    checkOutput("sbl.loadData", bus.loadData, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h80123456);
    idleCycle(1'b0, 32'h0);
    checkOutput("ubl.done", bus.done, 1);
    checkOutput("ubl.loadData", bus.loadData, 32'h00000080);

    // Misaligned half load faults immediately without touching the RAM.
    applyStimulus(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput("mis.done", bus.done, 1);
    checkOutput("mis.fault", bus.fault, 1);
    checkOutput("mis.memReq", bus.memReq, 0);
    checkOutput("mis.loadData", bus.loadData, 32'h00000080);

    // Silent RAM: request held MAX_WAIT cycles, then a faulted done.
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    reqCycles = 0;
    gotDone   = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      idleCycle(1'b0, 32'h0);
      if (bus.done) begin
        gotDone = 1'b1;
        checkOutput("tmo.fault", bus.fault, 1);
      end else if (bus.memReq) reqCycles++;
    end
    checkOutput("tmo.doneSeen", gotDone, 1);
    checkOutput("tmo.reqCycles", reqCycles, 15);
    checkOutput("tmo.loadData", bus.loadData, 32'h00000080);

    // Ack on the last allowed cycle wins over the timeout.
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 15; i++) idleCycle(i == 15, 32'hCAFEF00D);
    checkOutput("ack15.memReq", bus.memReq, 1);
    idleCycle(1'b0, 32'h0);
    checkOutput("ack15.done", bus.done, 1);
    checkOutput("ack15.fault", bus.fault, 0);
    checkOutput("ack15.loadData", bus.loadData, 32'hCAFEF00D);

    // Reset asserted mid-request drops the request and suppresses done.
    applyStimulus(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h12345678, 1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput("rmid.memReqBefore", bus.memReq, 1);
    idleCycle(1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rmid.memReqDropped", bus.memReq, 0);
    checkOutput("rmid.busyDropped", bus.busy, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    idleCycle(1'b0, 32'h0);
    checkOutput("rmid.noDone", bus.done, 0);
    idleCycle(1'b0, 32'h0);
    checkOutput("rmid.noDone2", bus.done, 0);
    applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0, 1'b0, 32'h0);
    idleCycle(1'b1, 32'h0BADF00D);
    checkOutput("rmid.memAddr0", bus.memAddr, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput("rmid.done", bus.done, 1);
    checkOutput("rmid.fault", bus.fault, 0);
    checkOutput("rmid.loadData", bus.loadData, 32'h0BADF00D);

    // start held high: a new access is only taken once the unit is back in IDLE.
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11110000 + 32'(i));
      if (bus.done) doneCnt++;
    end
    checkOutput("held.loadData", bus.loadData, 32'h11110004);
    for (int i = 0; i < 3; i++) begin
      idleCycle(1'b0, 32'h0);
      if (bus.done) doneCnt++;
    end
    checkOutput("held.doneCount", doneCnt, 2);

    // Randomized traffic in blocks with different RAM responsiveness.
    for (int blk = 0; blk < 32; blk++) begin
      int ackPct;
      case (blk % 4)
        0:       ackPct = 0;
        1:       ackPct = 15;
        2:       ackPct = 50;
        default: ackPct = 100;
      endcase
      for (int c = 0; c < 90; c++) begin
        logic [31:0] a;
        logic [1:0]  sz;
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        sz = ($urandom_range(0, 7) == 0) ? SZ_ILLEGAL : 2'($urandom_range(0, 2));
        applyStimulus($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), sz,
                      1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 99) < ackPct, $urandom);
      end
    end
    repeat (20) idleCycle(1'b0, 32'h0);
    checkOutput("final.idle", bus.busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width (multiple of 8, at least 16).
REQ-002 The block SHALL have parameter AWIDTH, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 15, meaning the number of REQ cycles without memAck before timeout.
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset: clk  input  1  clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request strobe, sampled only in IDLE.
REQ-007 isStore  input  1  1 = store, 0 = load.
REQ-008 size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 signedLd  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-010 addrIn  input  AWIDTH  byte address.
REQ-011 storeData  input  WIDTH  store data, right-justified.
REQ-012 memRData  input  WIDTH  RAM read data, valid with memAck.
REQ-013 memAck  input  1  RAM completion.
REQ-014 memReq  output  1  RAM request, held until ack or timeout.
REQ-015 memWr  output  1  write qualifier.
REQ-016 memAddr  output  AWIDTH  word-aligned address (low log2(WIDTH/8) bits zero).
REQ-017 memBe  output  WIDTH/8  byte-lane enables.
REQ-018 memWData  output  WIDTH  lane-replicated store data.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 fault  output  1  qualifies done: misaligned, illegal size or timeout.
REQ-022 loadData  output  WIDTH  registered, extended load result.

Function
REQ-023 States SHALL be IDLE, REQ, RESP: IDLE->REQ on start with legal aligned access; IDLE->RESP with fault on misalignment/illegal size; REQ->RESP on memAck or timeout; RESP->IDLE unconditionally.
REQ-024 On start in IDLE the block SHALL latch addrIn, size, isStore, signedLd and storeData; inputs SHALL be ignored afterwards until IDLE.
REQ-025 start while busy SHALL be ignored (no queueing); memAck outside REQ SHALL be ignored.
REQ-026 Misaligned SHALL mean half with addr[0]=1, or word with any offset bit set; no memReq SHALL be issued for it.
REQ-027 memReq, memWr, memAddr, memBe and memWData SHALL be registered and stable for every REQ cycle; memWr=memBe=0 outside REQ.
REQ-028 memBe SHALL be one lane (byte), two adjacent lanes (half) or all ones (word) at the latched offset; loads drive memBe too.
REQ-029 memWData SHALL replicate the low byte/half of storeData across all lanes, full word unchanged.
REQ-030 A wait counter SHALL clear on REQ entry, increment per REQ cycle without memAck, and on reaching MAX_WAIT force RESP with fault=1.
REQ-031 memAck on the same cycle the counter reaches MAX_WAIT SHALL win (success, no fault).
REQ-032 On a load ack, loadData SHALL capture the selected lanes, sign- or zero-extended to WIDTH; stores and faulted accesses SHALL leave loadData unchanged.
REQ-033 Latency: start at cycle 0, memReq from cycle 1; ack in cycle k gives done=1 in cycle k+1; minimum start-to-done 2 cycles; misaligned start gives done=fault=1 in cycle 1.
REQ-034 done and fault SHALL be high only in RESP, for exactly one cycle.

Reset
REQ-035 reset SHALL asynchronously force IDLE, wait counter 0, memReq=memWr=0, memBe=0, memAddr=0, memWData=0, done=fault=busy=0, loadData=0.
REQ-036 reset mid-REQ SHALL drop memReq immediately with no done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-037 A shared package lsu_pkg SHALL hold the state encoding and size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-038 Lane extraction plus sign/zero extension SHALL be one combinational sub-module, lsu_align, reused for load data.

Verification
REQ-039 Word store, addrIn=0x100, storeData=0xDEADBEEF, ack after 2 wait cycles -> memAddr=0x100, memBe=1111, memWr=1, done at cycle 4, fault=0.
REQ-040 Signed byte load, addrIn=0x203, lane 3 = 0x80 -> memBe=1000, loadData=0xFFFFFF80; repeat unsigned -> 0x00000080.
REQ-041 Half load addrIn=0x101 -> no memReq, done=fault=1 in cycle 1, loadData unchanged.
REQ-042 Load with memAck never asserted -> memReq high 15 cycles, then done=fault=1; ack on 15th cycle instead -> fault=0.
REQ-043 reset pulsed during REQ of a store -> memReq low same cycle, no done; next word load 0x000 completes normally.
REQ-044 start held high across a transaction -> second access begins only from IDLE, one done per accepted access.
